// File: rtl/writeback_if.sv
// Writeback-stage bus: execute-stage offer, load response and register-file write port.
// master drives the execute/memory side, slave is the writeback stage itself.
interface writeback_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              ex_valid;
  logic              ex_ready;
  logic              flush;
  logic [WIDTH-1:0]  ex_pc;
  logic [WIDTH-1:0]  ex_alu_result;
  logic [ADDR_W-1:0] ex_rd;
  logic              ex_reg_write;
  logic [1:0]        ex_result_src;
  logic [2:0]        ex_funct3;
  logic              mem_rvalid;
  logic [WIDTH-1:0]  mem_rdata;
  logic              wr_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic              retire_valid;

  modport master (
    output ex_valid, flush, ex_pc, ex_alu_result, ex_rd, ex_reg_write,
           ex_result_src, ex_funct3, mem_rvalid, mem_rdata,
    input  ex_ready, wr_en, rd_addr, rd_data, retire_valid
  );

  modport slave (
    input  ex_valid, flush, ex_pc, ex_alu_result, ex_rd, ex_reg_write,
           ex_result_src, ex_funct3, mem_rvalid, mem_rdata,
    output ex_ready, wr_en, rd_addr, rd_data, retire_valid
  );
endinterface

// File: rtl/writeback.sv
// Writeback stage: commits ALU/PC+4 results and aligned load data to the register file.
// Latency 1 for non-loads, 1 after mem_rvalid for loads; ex_ready low while a load waits.
// Optional 64-bit retired-instruction counter (instret) when RETIRE_CNT_EN is defined.
module writeback #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  writeback_if.slave  bus
`ifdef RETIRE_CNT_EN
  ,
  output logic [63:0] instret
`endif
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ld_rd;
  logic              ld_we;
  logic [2:0]        ld_f3;
  logic [1:0]        ld_off;

  logic              wr_en_q, retire_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [WIDTH-1:0]  rd_data_q;

  logic              accept, is_load, commit, we_nxt;
  logic [ADDR_W-1:0] rd_nxt;
  logic [WIDTH-1:0]  data_nxt, load_data;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  assign bus.ex_ready     = (state == IDLE);
  assign bus.wr_en        = wr_en_q;
  assign bus.rd_addr      = rd_addr_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.retire_valid = retire_q;

  // Load alignment uses the offset/size captured at accept time, not the live ex_* inputs.
  always_comb begin
    byte_v    = bus.mem_rdata[7:0];
    half_v    = ld_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    load_data = bus.mem_rdata;
    case (ld_off)
      2'd0:    byte_v = bus.mem_rdata[7:0];
      2'd1:    byte_v = bus.mem_rdata[15:8];
      2'd2:    byte_v = bus.mem_rdata[23:16];
      default: byte_v = bus.mem_rdata[31:24];
    endcase
    case (ld_f3)
      3'b000:  load_data = {{(WIDTH-8){byte_v[7]}}, byte_v};
      3'b100:  load_data = {{(WIDTH-8){1'b0}}, byte_v};
      3'b001:  load_data = {{(WIDTH-16){half_v[15]}}, half_v};
      3'b101:  load_data = {{(WIDTH-16){1'b0}}, half_v};
      default: load_data = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    we_nxt    = 1'b0;
    rd_nxt    = '0;
    data_nxt  = '0;
    accept    = bus.ex_valid && (state == IDLE) && !bus.flush;
    is_load   = (bus.ex_result_src == 2'b01);
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_load) begin
            state_nxt = WAIT_MEM;
          end else begin
            commit   = 1'b1;
            we_nxt   = bus.ex_reg_write && (bus.ex_rd != '0);
            rd_nxt   = bus.ex_rd;
            data_nxt = (bus.ex_result_src == 2'b10) ? bus.ex_pc + WIDTH'(4)
                                                    : bus.ex_alu_result;
          end
        end
      end
      WAIT_MEM: begin
        // flush is deliberately ignored here: an accepted load always completes.
        if (bus.mem_rvalid) begin
          commit    = 1'b1;
          we_nxt    = ld_we && (ld_rd != '0);
          rd_nxt    = ld_rd;
          data_nxt  = load_data;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_en_q   <= 1'b0;
      retire_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      ld_rd     <= '0;
      ld_we     <= 1'b0;
      ld_f3     <= 3'b000;
      ld_off    <= 2'b00;
    end else begin
      state    <= state_nxt;
      wr_en_q  <= commit && we_nxt;
      retire_q <= commit;
      if (commit) begin
        rd_addr_q <= rd_nxt;
        rd_data_q <= data_nxt;
      end
      if (accept && is_load) begin
        ld_rd  <= bus.ex_rd;
        ld_we  <= bus.ex_reg_write;
        ld_f3  <= bus.ex_funct3;
        ld_off <= bus.ex_alu_result[1:0];
      end
    end
  end

`ifdef RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)           instret <= '0;
    else if (retire_q) instret <= instret + 64'd1;
  end
`endif

endmodule
